ex_muldiv_sequencer: RTL
========================

// Module: ex_muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide unit plus its sequencing FSM, attached beside the EX-stage ALU.
//  Accepts one M-extension op from EX and holds EX via stall_o while it iterates.
//  Presents a 32-bit result with result_valid until the pipeline advances.
//  Radix-2: one product/quotient bit per cycle.
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  6   iteration counter width (>= clog2(XLEN)+1)
// PORTS
//  clk           in   1     clock, all state on posedge
//  rst           in   1     reset, asynchronous, active-low
//  start_i       in   1     EX holds a valid M-op (opcode op_reg, funct7 0000001)
//  funct3_i      in   3     muldiv_funct3_t: mul,mulh,mulhsu,mulhu,div,divu,rem,remu
//  op_a_i        in   XLEN  rs1 value after EX forwarding
//  op_b_i        in   XLEN  rs2 value after EX forwarding
//  flush_i       in   1     kill in-flight op (branch taken / redirect)
//  ack_i         in   1     EX/MEM register loads this cycle (= !MA_stall && !other stall)
//  stall_o       out  1     hold IF/ID/EX; combinational
//  result_valid  out  1     result_o holds the final value
//  result_o      out  XLEN  product/quotient/remainder
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all internal regs 0; result_valid=0, result_o=0, stall_o=0.
//  States: IDLE, CALC, DONE.
//   IDLE: if start_i && !flush_i -> latch magnitudes, signs, funct3; counter=0 -> CALC.
//         Special-case divide -> DONE directly (1-cycle latency).
//   CALC: one iteration per cycle, counter++.
//         counter==XLEN-1 -> apply sign fixup, write result_o -> DONE.
//   DONE: result_valid=1. ack_i -> IDLE. !ack_i -> hold result_o unchanged.
//  stall_o = (IDLE && start_i && !flush_i) || CALC. Deasserted in DONE.
//  Latency: start accepted at cycle 0; result_valid high at cycle XLEN+1 (33);
//   the op leaves EX on the first DONE cycle with ack_i=1.
//  start_i in DONE is the same instruction and is ignored; the next op is accepted only from IDLE.
//  Multiply: unsigned shift-add on |a|,|b| into a 2*XLEN accumulator.
//   Signedness: mul, mulh signed x signed; mulhsu signed x unsigned; mulhu unsigned.
//   Negate the 64-bit product if the operand signs differ.
//   mul returns [XLEN-1:0]; mulh* return [2*XLEN-1:XLEN].
//  Divide: restoring, unsigned on magnitudes.
//   Signed quotient is negated if the signs differ; remainder takes the dividend sign.
//  Divide special cases, resolved in IDLE, 1 cycle:
//   b==0: quotient = all ones (0xFFFFFFFF), remainder = a.
//   div/rem with a=0x80000000, b=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
//  flush_i in any state -> IDLE next edge; result_valid=0; no result produced.
//  flush_i wins over start_i and over ack_i in the same cycle.
//  Reset asserted mid-op: immediate return to reset values; the partial op is discarded.
//  All arithmetic is modulo 2^XLEN / 2^(2*XLEN); X-free for any operands.
// STRUCTURE
//  Shared package rv32i_types:
//   muldiv_funct3_t enum; localparam MULDIV_FUNCT7 = 7'b0000001.
//  Local to this module: state enum {IDLE, CALC, DONE}.
//  Sub-module muldiv_datapath:
//   holds the accumulator/remainder/quotient shift registers;
//   does one iteration per `step` pulse and the sign fixup on `finish`.
//   ex_muldiv_sequencer owns the FSM, counter, special-case detection and the handshake.
// TESTING
//  1. mul 7 x 6 -> stall_o high 33 cycles, then result_valid=1, result_o=42; ack_i -> IDLE.
//  2. mulh 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; mulhu same operands -> 0xFFFFFFFE.
//     mulhsu 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  3. div -7/2 -> 0xFFFFFFFD (-3); rem -7/2 -> 0xFFFFFFFF (-1).
//     divu 100/7 -> 14; remu 100/7 -> 2.
//  4. divu 5/0 -> 0xFFFFFFFF in 1 cycle; rem 5/0 -> 5.
//     div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0.
//  5. flush_i at CALC cycle 10 -> IDLE next edge, stall_o=0, result_valid never asserts.
//     start_i+flush_i together -> not accepted.
//  6. DONE with ack_i=0 for 5 cycles -> result_o stable, start_i ignored.
//     rst low mid-CALC -> all outputs 0 immediately; back-to-back ops after ack both correct.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 type definitions used by the EX-stage M-extension unit.
//   muldiv_funct3_t : funct3 encodings of the eight RV32M operations
//   MULDIV_FUNCT7   : funct7 value that marks an OP-class instruction as RV32M
package rv32i_types;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } muldiv_funct3_t;

endpackage

// File: rtl/ex_muldiv_sequencer_datapath.sv
// Radix-2 multiply/divide datapath: shift registers for the running
// product / partial remainder + quotient, one iteration per step pulse,
// and sign fixup of the final value into the result register on finish.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load              capture operand magnitudes, clear the accumulator
//   step              perform one iteration
//   finish            with step: fixup the post-iteration value into result
//   special           load special_value straight into result
//   is_div            iterate as restoring divide (else shift-add multiply)
//   sel_hi            multiply: return the upper half of the product
//   sel_rem           divide: return the remainder (else the quotient)
//   negate            two's-complement the selected value
//   mag_a, mag_b      operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   special_value     precomputed result for the divide corner cases
//   result            final product/quotient/remainder
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  logic            special,
    input  logic            is_div,
    input  logic            sel_hi,
    input  logic            sel_rem,
    input  logic            negate,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    input  logic [XLEN-1:0] special_value,
    output logic [XLEN-1:0] result
);

    // hi: product upper half / partial remainder; lo: multiplier bits / quotient bits
    logic [XLEN-1:0]   opnd, hi, lo;
    logic [XLEN-1:0]   hi_nxt, lo_nxt, addend;
    logic [XLEN:0]     sum, trial;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, fixed;

    assign addend = lo[0] ? opnd : '0;
    assign sum    = {1'b0, hi} + {1'b0, addend};
    // Shift in the next dividend bit and try subtracting the divisor; the
    // top bit of the XLEN+1 wide difference is the borrow.
    assign trial  = {hi, lo[XLEN-1]} - {1'b0, opnd};

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (is_div) begin
            if (!trial[XLEN]) begin
                hi_nxt = trial[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = {hi[XLEN-2:0], lo[XLEN-1]};
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_nxt, lo_nxt} = {sum, lo[XLEN-1:1]};
        end
    end

    // Fixup acts on the value after the final iteration, so the last step
    // and the result write share one clock edge.
    assign prod     = {hi_nxt, lo_nxt};
    assign prod_fix = negate ? -prod : prod;
    assign div_raw  = sel_rem ? hi_nxt : lo_nxt;
    assign div_fix  = negate ? -div_raw : div_raw;
    assign fixed    = is_div ? div_fix
                    : (sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

    // NOTE: the working registers are reset even though load overwrites
    // them, so the unit never carries X into result after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
        end else begin
            if (load) begin
                opnd <= mag_b;
                lo   <= mag_a;
                hi   <= '0;
            end else if (step) begin
                hi <= hi_nxt;
                lo <= lo_nxt;
            end

            if (special) begin
                result <= special_value;
            end else if (finish) begin
                result <= fixed;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU. Accepts one
// M-op, stalls EX while iterating (one bit per cycle), then presents the
// result with result_valid until the EX/MEM register takes it.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start_i        EX holds a valid M-op
//   funct3_i       muldiv_funct3_t operation select
//   op_a_i, op_b_i forwarded rs1 / rs2 values
//   flush_i        kill the in-flight op (wins over start_i and ack_i)
//   ack_i          EX/MEM register loads this cycle
//   stall_o        hold IF/ID/EX (combinational)
//   result_valid   result_o holds the final value
//   result_o       product / quotient / remainder
module ex_muldiv_sequencer
    import rv32i_types::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    input  logic            ack_i,
    output logic            stall_o,
    output logic            result_valid,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    muldiv_funct3_t   f3_in, f3_q;
    logic             neg_a_q, neg_b_q;
    logic             signed_a, signed_b, neg_a, neg_b;
    logic             accept, special, step, finish;
    logic [XLEN-1:0]  mag_a, mag_b, special_value;

    assign f3_in    = muldiv_funct3_t'(funct3_i);
    assign signed_a = !(f3_in inside {F3_MULHU, F3_DIVU, F3_REMU});
    assign signed_b = f3_in inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    assign neg_a    = signed_a && op_a_i[XLEN-1];
    assign neg_b    = signed_b && op_b_i[XLEN-1];
    assign mag_a    = neg_a ? -op_a_i : op_a_i;
    assign mag_b    = neg_b ? -op_b_i : op_b_i;

    // Divide by zero and signed overflow bypass iteration entirely.
    assign special = funct3_i[2]
                   && ((op_b_i == '0)
                       || (!funct3_i[0] && op_a_i == MIN_NEG && op_b_i == '1));
    // funct3[1] separates rem* from div* within the divide group.
    assign special_value = (op_b_i == '0) ? (funct3_i[1] ? op_a_i : '1)
                                          : (funct3_i[1] ? '0 : MIN_NEG);

    // rst is included so stall_o is held low while reset is asserted.
    assign accept       = rst && (state == IDLE) && start_i && !flush_i;
    assign step         = (state == CALC) && !flush_i;
    assign finish       = step && (counter == LAST_CNT);
    assign stall_o      = accept || (state == CALC);
    assign result_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
            f3_q    <= F3_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q    <= f3_in;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        counter <= '0;
                        state   <= special ? DONE : CALC;
                    end
                end
                CALC: begin
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // start_i here is the same instruction still sitting in EX.
                    if (ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk           (clk),
        .rst           (rst),
        .load          (accept),
        .step          (step),
        .finish        (finish),
        .special       (accept && special),
        .is_div        (f3_q[2]),
        .sel_hi        (f3_q != F3_MUL),
        .sel_rem       (f3_q[1]),
        // Remainder follows the dividend sign; everything else the sign product.
        .negate        ((f3_q[2] && f3_q[1]) ? neg_a_q : (neg_a_q ^ neg_b_q)),
        .mag_a         (mag_a),
        .mag_b         (mag_b),
        .special_value (special_value),
        .result        (result_o)
    );

endmodule
